id_ex_stage_buf: RTL and testbench

- Parametrised ID→EX pipeline stage that replaces the plain hold-enabled register bank.
- Carries an opaque decoded-instruction payload, plus the instruction address and rd fields as first-class fields.
- Uses a valid/ready handshake with a 2-entry skid buffer, so InReady is registered and no combinational OutReady→InReady path exists.
- Adds synchronous flush (bubble insertion on branch/jump redirect) and saturating stall/bubble/flush performance counters for the EX stage.

---
 rtl/id_ex_stage_buf.sv | 179 +++++++++++++++++
 tb/tb_id_ex_stage_buf.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_buf.sv
// ID->EX pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
// InReady is a register (high whenever the skid entry will be empty), so there is
// no combinational OutReady->InReady path. Flush drops everything held and
// anything accepted in the same cycle. Saturating counters track EX-side
// stalls, bubbles and flushes.
//
// Ports:
//   Clk, Rst                  clock, synchronous active-high reset
//   InValid / InReady         upstream handshake (InReady registered)
//   InInstAddr, InRdAddr,     incoming instruction fields
//   InRdWriteEnable, InPayload
//   Flush                     invalidate main and skid entries
//   OutValid / OutReady       downstream handshake
//   OutInstAddr, OutRdAddr,   main-entry fields (OutRdWriteEnable gated by OutValid)
//   OutRdWriteEnable, OutPayload
//   StallCount, BubbleCount,  saturating performance counters
//   FlushCount
module id_ex_stage_buf #(
  parameter int unsigned PAYLOAD_WIDTH = 192,
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter logic [ADDR_WIDTH-1:0] ADDR_INIT = ADDR_WIDTH'(64'h8000_0000),
  parameter int unsigned RD_WIDTH      = 5,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [ADDR_WIDTH-1:0]    InInstAddr,
  input  logic [RD_WIDTH-1:0]      InRdAddr,
  input  logic                     InRdWriteEnable,
  input  logic [PAYLOAD_WIDTH-1:0] InPayload,
  input  logic                     Flush,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [ADDR_WIDTH-1:0]    OutInstAddr,
  output logic [RD_WIDTH-1:0]      OutRdAddr,
  output logic                     OutRdWriteEnable,
  output logic [PAYLOAD_WIDTH-1:0] OutPayload,
  output logic [CNT_WIDTH-1:0]     StallCount,
  output logic [CNT_WIDTH-1:0]     BubbleCount,
  output logic [CNT_WIDTH-1:0]     FlushCount
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                     r_in_ready;
  logic [ADDR_WIDTH-1:0]    r_main_addr, r_skid_addr;
  logic [RD_WIDTH-1:0]      r_main_rd,   r_skid_rd;
  logic                     r_main_rdwe, r_skid_rdwe;
  logic [PAYLOAD_WIDTH-1:0] r_main_pl,   r_skid_pl;
  logic [CNT_WIDTH-1:0]     r_stall_cnt, r_bubble_cnt, r_flush_cnt;

  logic w_in_fire;
  logic w_out_valid;
  logic w_out_fire;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_fire   = InValid & r_in_ready;
  assign w_out_fire  = w_out_valid & OutReady;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt    = S_ONE;
          w_load_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = S_FULL;
          w_load_skid = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        // InReady is low here, so only the drain transition is possible
        if (w_out_fire) begin
          w_state_nxt      = S_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // Flush discards held and same-cycle accepted entries; data regs keep their contents
    if (Flush) begin
      w_state_nxt      = S_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_FULL);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_main_addr <= ADDR_INIT;
      r_main_rd   <= '0;
      r_main_rdwe <= 1'b0;
      r_main_pl   <= '0;
      r_skid_addr <= '0;
      r_skid_rd   <= '0;
      r_skid_rdwe <= 1'b0;
      r_skid_pl   <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_addr <= InInstAddr;
        r_main_rd   <= InRdAddr;
        r_main_rdwe <= InRdWriteEnable;
        r_main_pl   <= InPayload;
      end else if (w_load_main_skid) begin
        r_main_addr <= r_skid_addr;
        r_main_rd   <= r_skid_rd;
        r_main_rdwe <= r_skid_rdwe;
        r_main_pl   <= r_skid_pl;
      end
      if (w_load_skid) begin
        r_skid_addr <= InInstAddr;
        r_skid_rd   <= InRdAddr;
        r_skid_rdwe <= InRdWriteEnable;
        r_skid_pl   <= InPayload;
      end
    end
  end

  // Stall/bubble use the pre-flush OutValid, so a flush cycle still counts them
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_out_valid && !OutReady && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      if (!w_out_valid && OutReady && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + CNT_WIDTH'(1);
      if (Flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
    end
  end

  assign InReady          = r_in_ready;
  assign OutValid         = w_out_valid;
  assign OutInstAddr      = r_main_addr;
  assign OutRdAddr        = r_main_rd;
  assign OutRdWriteEnable = r_main_rdwe & w_out_valid;
  assign OutPayload       = r_main_pl;
  assign StallCount       = r_stall_cnt;
  assign BubbleCount      = r_bubble_cnt;
  assign FlushCount       = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Randomised and directed bench for id_ex_stage_buf. A queue-based model
// (at most two in-flight entries, FIFO) predicts every output each cycle.
module tb_id_ex_stage_buf;

  localparam int unsigned PW   = 192;
  localparam int unsigned AW   = 64;
  localparam int unsigned RW   = 5;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = 15;
  localparam logic [AW-1:0] AINIT = 64'h8000_0000;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          InValid;
  logic          InReady;
  logic [AW-1:0] InInstAddr;
  logic [RW-1:0] InRdAddr;
  logic          InRdWriteEnable;
  logic [PW-1:0] InPayload;
  logic          Flush;
  logic          OutValid;
  logic          OutReady;
  logic [AW-1:0] OutInstAddr;
  logic [RW-1:0] OutRdAddr;
  logic          OutRdWriteEnable;
  logic [PW-1:0] OutPayload;
  logic [CW-1:0] StallCount;
  logic [CW-1:0] BubbleCount;
  logic [CW-1:0] FlushCount;

  always #5 Clk = ~Clk;

  id_ex_stage_buf #(
    .PAYLOAD_WIDTH(PW),
    .ADDR_WIDTH(AW),
    .ADDR_INIT(AINIT),
    .RD_WIDTH(RW),
    .CNT_WIDTH(CW)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .InValid(InValid),
    .InReady(InReady),
    .InInstAddr(InInstAddr),
    .InRdAddr(InRdAddr),
    .InRdWriteEnable(InRdWriteEnable),
    .InPayload(InPayload),
    .Flush(Flush),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .OutInstAddr(OutInstAddr),
    .OutRdAddr(OutRdAddr),
    .OutRdWriteEnable(OutRdWriteEnable),
    .OutPayload(OutPayload),
    .StallCount(StallCount),
    .BubbleCount(BubbleCount),
    .FlushCount(FlushCount)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [RW-1:0] rd;
    logic          we;
    logic [PW-1:0] pl;
  } ent_t;

  ent_t        q[$];
  ent_t        shown;
  bit          m_ready;
  int unsigned m_stall, m_bubble, m_flush;
  bit          last_fire, last_flush;
  bit          force_we;
  logic [AW-1:0] next_addr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit   vld;
    ent_t cur;
    vld = (q.size() > 0);
    cur = '{addr: InInstAddr, rd: InRdAddr, we: InRdWriteEnable, pl: InPayload};
    if (Rst) begin
      q.delete();
      shown      = '{addr: AINIT, rd: '0, we: 1'b0, pl: '0};
      m_ready    = 1'b0;
      m_stall    = 0;
      m_bubble   = 0;
      m_flush    = 0;
      last_fire  = 1'b0;
      last_flush = 1'b0;
    end else begin
      last_fire  = InValid && m_ready;
      last_flush = Flush;
      if (vld && !OutReady && m_stall < CMAX) m_stall++;
      if (!vld && OutReady && m_bubble < CMAX) m_bubble++;
      if (Flush && m_flush < CMAX) m_flush++;
      if (Flush) begin
        q.delete();
      end else begin
        if (vld && OutReady) void'(q.pop_front());
        if (last_fire) q.push_back(cur);
      end
      if (q.size() > 0) shown = q[0];
      m_ready = (q.size() < 2);
    end
  endtask

  task automatic check_outputs();
    bit vld;
    vld = (q.size() > 0);
    check_eq("out_valid", 256'(OutValid), 256'(vld));
    check_eq("in_ready", 256'(InReady), 256'(m_ready));
    check_eq("out_addr", 256'(OutInstAddr), 256'(shown.addr));
    check_eq("out_rd", 256'(OutRdAddr), 256'(shown.rd));
    check_eq("out_rdwe", 256'(OutRdWriteEnable), 256'(shown.we && vld));
    check_eq("out_payload", 256'(OutPayload), 256'(shown.pl));
    check_eq("stall_cnt", 256'(StallCount), 256'(m_stall));
    check_eq("bubble_cnt", 256'(BubbleCount), 256'(m_bubble));
    check_eq("flush_cnt", 256'(FlushCount), 256'(m_flush));
  endtask

  // Called at a negedge: drive inputs, advance one clock, update model, check.
  task automatic cycle(input bit want, input bit rdy, input bit fl, input bit rst);
    if (InValid && !last_fire && !last_flush) begin
      // producer holds an unaccepted instruction
    end else if (want) begin
      InValid         = 1'b1;
      InInstAddr      = next_addr;
      next_addr       = next_addr + 64'd4;
      InRdAddr        = RW'($urandom);
      InRdWriteEnable = force_we | 1'($urandom % 2);
      InPayload       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end else begin
      InValid = 1'b0;
    end
    OutReady = rdy;
    Flush    = fl;
    Rst      = rst;
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_outputs();
  endtask

  task automatic do_reset();
    InValid   = 1'b0;
    next_addr = AINIT;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    Rst = 1'b1; InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0;
    InInstAddr = '0; InRdAddr = '0; InRdWriteEnable = 1'b0; InPayload = '0;
    force_we = 1'b0; last_fire = 1'b0; last_flush = 1'b0;
    next_addr = AINIT;
    @(negedge Clk);
    do_reset();

    // Stream of four consecutive addresses with OutReady held high
    for (int i = 0; i < 10; i++) cycle(i < 4, 1'b1, 1'b0, 1'b0);

    // Backpressure: fill main and skid, then release
    do_reset();
    for (int i = 0; i < 6; i++) cycle(i < 3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);

    // Flush while full with a third instruction offered
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("flush_full_valid", 256'(OutValid), 256'(0));
    check_eq("flush_full_ready", 256'(InReady), 256'(1));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset while full
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("midrst_addr", 256'(OutInstAddr), 256'(AINIT));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);

    // Counter saturation: long stall
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("stall_saturated", 256'(StallCount), 256'(4'hF));

    // Bubble gating: write-enabled entry drained, then idle
    do_reset();
    force_we = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    force_we = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 4) != 0, ($urandom % 3) != 0,
            ($urandom % 16) == 0, ($urandom % 64) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
